// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One transaction in flight at a time: IDLE (accept) -> EXEC (capture) -> RESP (hand back).
module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_a,
    input  logic [DATA_WIDTH-1:0]    req0_b,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic [8:0]               req0_pc,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [DATA_WIDTH-1:0]    rsp0_data,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_a,
    input  logic [DATA_WIDTH-1:0]    req1_b,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    input  logic [8:0]               req1_pc,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DATA_WIDTH-1:0]    rsp1_data,

    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    output logic [8:0]               alu_pc,
    input  logic [DATA_WIDTH-1:0]    alu_result,

    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   r_state;
    logic                     r_owner;
    logic                     r_last_grant;
    logic                     r_rsp0_valid;
    logic                     r_rsp1_valid;
    logic                     r_busy;
    logic [DATA_WIDTH-1:0]    r_a;
    logic [DATA_WIDTH-1:0]    r_b;
    logic [DATA_WIDTH-1:0]    r_result;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic [8:0]               r_pc;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;
    logic w_take;

    // On a tie the requester that was not served last wins; rst_n gating keeps
    // both readies low while reset is held even though the state reads IDLE.
    assign w_idle   = (r_state == S_IDLE);
    assign w_grant0 = rst_n && w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = rst_n && w_idle && req1_valid && (!req0_valid || !r_last_grant);
    assign w_take   = r_owner ? rsp1_ready : rsp0_ready;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_data  = r_result;
    assign rsp1_data  = r_result;
    assign alu_srca   = r_a;
    assign alu_srcb   = r_b;
    assign alu_op     = r_op;
    assign alu_pc     = r_pc;
    assign busy       = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_op         <= '0;
            r_pc         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_owner <= w_grant1;
                        r_a     <= w_grant1 ? req1_a  : req0_a;
                        r_b     <= w_grant1 ? req1_b  : req0_b;
                        r_op    <= w_grant1 ? req1_op : req0_op;
                        r_pc    <= w_grant1 ? req1_pc : req0_pc;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result     <= alu_result;
                    r_rsp0_valid <= !r_owner;
                    r_rsp1_valid <= r_owner;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (w_take) begin
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_last_grant <= r_owner;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a small ALU and a
// transaction-level reference model (winner choice, result, timing).
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [8:0]  req0_pc, req1_pc;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_data, rsp1_data;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [3:0]  alu_op;
    logic [8:0]  alu_pc;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int last_m = 1;          // model: requester served most recently
    int txn_no = 0;

    alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .req0_pc(req0_pc),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .req1_pc(req1_pc),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op), .alu_pc(alu_pc),
        .alu_result(alu_result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b,
                                           logic [3:0] op, logic [8:0] pc);
        logic [31:0] r;
        case (op)
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0100: r = a ^ b;
            4'b1000: r = $signed(a) >>> b[4:0];
            4'b1101: r = {23'd0, pc} + 32'd4;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign alu_result = alu_fn(alu_srca, alu_srcb, alu_op, alu_pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [8:0] pc);
        if (n == 0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_pc = pc;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_pc = pc;
        end
    endtask

    // Starts and ends on a falling edge with the arbiter idle.
    task automatic run_txn(input bit v0, input bit v1, input int stall);
        int          w;
        logic [31:0] ea, eb, exp;
        logic [3:0]  eop;
        logic [8:0]  epc;
        if (v0 && !v1)      w = 0;
        else if (v1 && !v0) w = 1;
        else                w = (last_m == 1) ? 0 : 1;
        ea  = (w == 0) ? req0_a  : req1_a;
        eb  = (w == 0) ? req0_b  : req1_b;
        eop = (w == 0) ? req0_op : req1_op;
        epc = (w == 0) ? req0_pc : req1_pc;
        exp = alu_fn(ea, eb, eop, epc);

        req0_valid = v0;
        req1_valid = v1;
        rsp0_ready = (w == 0) ? (stall == 0) : 1'b1;
        rsp1_ready = (w == 1) ? (stall == 0) : 1'b1;
        #1;
        chk("idle_ready0", {31'd0, req0_ready}, {31'd0, w == 0});
        chk("idle_ready1", {31'd0, req1_ready}, {31'd0, w == 1});
        chk("idle_busy",   {31'd0, busy}, 32'd0);

        @(negedge clk);
        chk("exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("exec_busy",  {31'd0, busy}, 32'd1);
        chk("exec_rspv",  {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("exec_srca",  alu_srca, ea);
        chk("exec_srcb",  alu_srcb, eb);
        chk("exec_op",    {28'd0, alu_op}, {28'd0, eop});
        chk("exec_pc",    {23'd0, alu_pc}, {23'd0, epc});

        @(negedge clk);
        for (int k = 0; k <= stall; k++) begin
            chk("resp_rspv", {30'd0, rsp1_valid, rsp0_valid}, (w == 0) ? 32'd1 : 32'd2);
            chk("resp_data", (w == 0) ? rsp0_data : rsp1_data, exp);
            chk("resp_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            chk("resp_busy", {31'd0, busy}, 32'd1);
            chk("resp_srca", alu_srca, ea);
            if (k < stall) @(negedge clk);
        end
        if (w == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        @(negedge clk);
        chk("done_rspv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        last_m = w;
        $display("txn %0d: grant=%0d op=%b a=%h b=%h data=%h stall=%0d",
                 txn_no, w, eop, ea, eb, exp, stall);
        txn_no++;
    endtask

    logic [3:0] op_list [6] = '{4'b0010, 4'b0110, 4'b0100, 4'b1000, 4'b1101, 4'b1111};

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        set_req(0, 32'd0, 32'd0, 4'd0, 9'd0);
        set_req(1, 32'd0, 32'd0, 4'd0, 9'd0);
        #2;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_rspv",   {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_srca",   alu_srca, 32'd0);
        chk("rst_data",   rsp0_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b0;

        // single ADD
        set_req(0, 32'd5, 32'd7, 4'b0010, 9'd0);
        run_txn(1, 0, 0);

        // tie after idle: SUB on req0, XOR on req1
        set_req(0, 32'd10, 32'd3, 4'b0110, 9'd0);
        set_req(1, 32'hF0, 32'hFF, 4'b0100, 9'd0);
        run_txn(1, 1, 0);
        run_txn(0, 1, 0);

        // round-robin with both held valid
        for (int i = 0; i < 6; i++) begin
            set_req(0, $urandom, $urandom, 4'b0010, 9'd0);
            set_req(1, $urandom, $urandom, 4'b0110, 9'd0);
            run_txn(1, 1, 0);
            chk("rr_order", last_m, i % 2);
        end

        // backpressure on SRA from requester 1, requester 0 waiting
        set_req(1, 32'h8000_0000, 32'd4, 4'b1000, 9'd0);
        run_txn(0, 1, 5);
        req1_valid = 1'b0;
        run_txn(1, 0, 0);

        // JAL, then reset during EXEC
        set_req(0, 32'd0, 32'd0, 4'b1101, 9'h10);
        run_txn(1, 0, 0);
        set_req(0, 32'd9, 32'd9, 4'b0010, 9'd0);
        req0_valid = 1'b1;
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy",   {31'd0, busy}, 32'd0);
        chk("arst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("arst_srca",   alu_srca, 32'd0);
        #2;
        rst_n = 1'b1;
        req0_valid = 1'b0;
        last_m = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_rspv", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        set_req(0, 32'd100, 32'd23, 4'b0010, 9'd0);
        set_req(1, 32'd1, 32'd2, 4'b0100, 9'd0);
        run_txn(1, 1, 0);

        // randomized traffic
        for (int i = 0; i < 12; i++) begin
            int vp;
            set_req(0, $urandom, $urandom, op_list[$urandom_range(0, 5)], 9'($urandom));
            set_req(1, $urandom, $urandom, op_list[$urandom_range(0, 5)], 9'($urandom));
            vp = $urandom_range(1, 3);
            run_txn(vp[0], vp[1], $urandom_range(0, 3));
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
